// File: rtl/bus_sync_launch.sv
// Source-domain launcher for a bus crossing into a retime-and-stability-check receiver.
// Each launched word is held on o_data_a for at least HOLD_CYCLES source cycles.
module bus_sync_launch #(
  parameter int unsigned          BUS_WIDTH   = 1,
  parameter int unsigned          HOLD_CYCLES = 8,
  parameter logic [BUS_WIDTH-1:0] RESET_VALUE = '0,
  parameter bit                   OVERWRITE   = 1'b1,
  parameter bit                   SKIP_EQUAL  = 1'b0
) (
  input  logic                 i_clk_a,
  input  logic                 i_rstn_a,
  input  logic [BUS_WIDTH-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [BUS_WIDTH-1:0] o_data_a,
  output logic                 o_launch,
  output logic                 o_drop,
  output logic                 o_busy
);

  localparam int unsigned    CntW      = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntReload = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [BUS_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 launch_q, launch_d;
  logic                 drop_q, drop_d;
  logic                 busy_q, busy_d;
  logic                 xfer;

  always_ff @(posedge i_clk_a or negedge i_rstn_a) begin
    if (!i_rstn_a) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      data_q       <= RESET_VALUE;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      launch_q     <= 1'b0;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      launch_q     <= launch_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    launch_d     = 1'b0;
    drop_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (xfer && !(SKIP_EQUAL && (i_data == data_q))) begin
          data_d   = i_data;
          cnt_d    = CntReload;
          launch_d = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
          if (xfer) begin
            pend_data_d  = i_data;
            pend_valid_d = 1'b1;
            drop_d       = pend_valid_q;
          end
        end else if (pend_valid_q) begin
          // Pending word goes first; a simultaneous arrival refills the slot without loss.
          data_d       = pend_data_q;
          cnt_d        = CntReload;
          launch_d     = 1'b1;
          pend_valid_d = xfer;
          if (xfer) pend_data_d = i_data;
        end else if (xfer) begin
          data_d   = i_data;
          cnt_d    = CntReload;
          launch_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StHold) || pend_valid_d;
  end

  always_comb begin
    o_ready  = OVERWRITE ? 1'b1 : !pend_valid_q;
    xfer     = i_valid && o_ready;
    o_data_a = data_q;
    o_launch = launch_q;
    o_drop   = drop_q;
    o_busy   = busy_q;
  end

endmodule
